// File: rtl/score_hex_pkg.sv
// Shared definitions for the score hex driver: register map, bit positions,
// converter states and display constants.
package score_hex_pkg;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int unsigned CTRL_BLANK_LZ = 0;
    localparam int unsigned CTRL_EN       = 1;
    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_OVF      = 1;

    localparam int unsigned MAX_VALUE  = 999999;
    localparam int unsigned BCD_DIGITS = 6;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } conv_state_e;

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
    import score_hex_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = 7'h40;
                4'd1:    seg = 7'h79;
                4'd2:    seg = 7'h24;
                4'd3:    seg = 7'h30;
                4'd4:    seg = 7'h19;
                4'd5:    seg = 7'h12;
                4'd6:    seg = 7'h02;
                4'd7:    seg = 7'h78;
                4'd8:    seg = 7'h00;
                4'd9:    seg = 7'h10;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_hex_driver.sv
// Avalon-MM slave holding a binary score, converted to BCD by a serial
// double-dabble engine and shown on six active-low seven-segment digits.
module score_hex_driver
    import score_hex_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VALUE_W    = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);

    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
    localparam int unsigned BCD_W = 4 * BCD_DIGITS;

    conv_state_e          state_q, state_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic                 pending_q, pending_d;
    logic                 ovf_q, ovf_d;
    logic                 blank_lz_q, blank_lz_d;
    logic                 en_q, en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VALUE_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     disp_q, disp_d;

    logic                 wr;
    logic                 busy;
    logic                 sat;
    logic [BCD_W-1:0]     adj;
    logic [BCD_DIGITS-1:0] blank_vec;
    logic [6:0]           seg_all [BCD_DIGITS];
    logic                 unused_bits;

    assign wr          = chipselect & ~write_n;
    assign busy        = (state_q != ST_IDLE);
    assign sat         = (32'(value_q) > MAX_VALUE);
    assign unused_bits = ^{writedata, adj[BCD_W-1]};

    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Ordering matters: a STATUS clear loses to a saturating LOAD, and a
    // LOAD's pending clear loses to a coincident VALUE write.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        pending_d  = pending_q;
        ovf_d      = ovf_q;
        blank_lz_d = blank_lz_q;
        en_d       = en_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        disp_d     = disp_q;

        if (wr && address == ADDR_CTRL) begin
            blank_lz_d = writedata[CTRL_BLANK_LZ];
            en_d       = writedata[CTRL_EN];
        end
        if (wr && address == ADDR_STATUS && writedata[STAT_OVF]) ovf_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pending_d = 1'b0;
                bin_d     = sat ? VALUE_W'(MAX_VALUE) : value_q;
                if (sat) ovf_d = 1'b1;
                bcd_d     = '0;
                cnt_d     = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                disp_d  = bcd_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr && address == ADDR_VALUE) begin
            value_d   = writedata[VALUE_W-1:0];
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            pending_q  <= 1'b0;
            ovf_q      <= 1'b0;
            blank_lz_q <= 1'b0;
            en_q       <= 1'b1;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            blank_lz_q <= blank_lz_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            disp_q     <= disp_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_VALUE:  readdata = 32'(value_q);
            ADDR_CTRL:   readdata = {30'd0, en_q, blank_lz_q};
            ADDR_STATUS: readdata = {30'd0, ovf_q, busy};
            default:     readdata = '0;
        endcase
    end

    // Scan from the most-significant digit; zeros stay blank until the first nonzero.
    always_comb begin
        logic seen_nz;
        seen_nz   = 1'b0;
        blank_vec = '0;
        for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
            int unsigned idx;
            idx = BCD_DIGITS - 1 - k;
            blank_vec[idx] = ~en_q | (blank_lz_q & ~seen_nz & (idx != 0) &
                                      (disp_q[4*idx +: 4] == 4'd0));
            if (disp_q[4*idx +: 4] != 4'd0) seen_nz = 1'b1;
        end
    end

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        if (g < NUM_DIGITS) begin : g_dec
            seg7_decode u_dec (
                .bcd   (disp_q[4*g +: 4]),
                .blank (blank_vec[g]),
                .seg   (seg_all[g])
            );
        end else begin : g_off
            assign seg_all[g] = SEG_BLANK;
        end
    end

    assign hex0 = seg_all[0];
    assign hex1 = seg_all[1];
    assign hex2 = seg_all[2];
    assign hex3 = seg_all[3];
    assign hex4 = seg_all[4];
    assign hex5 = seg_all[5];

endmodule

// File: tb/tb_score_hex_driver.sv
// Self-checking bench for score_hex_driver against a decimal-arithmetic display model.
module tb_score_hex_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd2;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [6:0]  hex_o [6];

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bit          mon_on = 1'b0;
    logic [41:0] mon_last;
    logic [41:0] seen_q [$];

    score_hex_driver #(.NUM_DIGITS(6), .VALUE_W(20)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex0       (hex_o[0]),
        .hex1       (hex_o[1]),
        .hex2       (hex_o[2]),
        .hex3       (hex_o[3]),
        .hex4       (hex_o[4]),
        .hex5       (hex_o[5])
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(int unsigned v, bit en, bit blz, int unsigned i);
        int unsigned s, p;
        s = (v > 999999) ? 999999 : v;
        p = 1;
        for (int unsigned k = 0; k < i; k++) p = p * 10;
        if (!en) return 7'h7F;
        if (blz && i != 0 && s < p) return 7'h7F;
        return seg_tab[(s / p) % 10];
    endfunction

    function automatic logic [41:0] exp_pack(int unsigned v, bit en, bit blz);
        logic [41:0] r;
        for (int unsigned i = 0; i < 6; i++) r[7*i +: 7] = exp_seg(v, en, blz, i);
        return r;
    endfunction

    function automatic logic [41:0] cur_pack();
        return {hex_o[5], hex_o[4], hex_o[3], hex_o[2], hex_o[1], hex_o[0]};
    endfunction

    task automatic check_display(input string tag, input int unsigned v, input bit en, input bit blz);
        for (int unsigned i = 0; i < 6; i++)
            check_eq($sformatf("%s_hex%0d", tag, i), 32'(hex_o[i]), 32'(exp_seg(v, en, blz, i)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd2; writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
        address = 2'd2;
    endtask

    always @(negedge clk) begin
        if (mon_on && cur_pack() !== mon_last) begin
            seen_q.push_back(cur_pack());
            mon_last = cur_pack();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int unsigned v;
        bit en_m, blz_m, ovf_m;

        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // reset state
        check_display("rst", 0, 1, 0);
        rd(2'd2, r); check_eq("rst_status", r, 32'd0);
        rd(2'd1, r); check_eq("rst_ctrl", r, 32'd2);
        rd(2'd0, r); check_eq("rst_value", r, 32'd0);
        rd(2'd3, r); check_eq("rst_rsvd", r, 32'd0);

        // conversion latency
        wr(2'd0, 32'd123456);
        tick();
        rd(2'd2, r); check_eq("lat_busy_n1", r, 32'd1);
        repeat (21) tick();
        check_eq("lat_n22_old", 32'(cur_pack()), 32'(exp_pack(0, 1, 0)));
        check_eq("lat_n22_old_hi", 32'(cur_pack() >> 32), 32'(exp_pack(0, 1, 0) >> 32));
        tick();
        check_display("lat_n23", 123456, 1, 0);
        rd(2'd2, r); check_eq("lat_idle", r, 32'd0);

        // leading-zero blanking
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd42);
        repeat (23) tick();
        check_display("blz42", 42, 1, 1);
        wr(2'd0, 32'd0);
        repeat (23) tick();
        check_display("blz0", 0, 1, 1);

        // CTRL takes effect next cycle and starts no conversion
        wr(2'd1, 32'd0);
        check_display("en_off", 0, 0, 0);
        rd(2'd2, r); check_eq("en_off_nobusy", r, 32'd0);
        wr(2'd1, 32'd2);
        check_display("en_on", 0, 1, 0);

        // saturation and sticky ovf
        wr(2'd0, 32'd1000000);
        repeat (23) tick();
        check_display("sat", 1000000, 1, 0);
        rd(2'd2, r); check_eq("sat_status", r, 32'd2);
        rd(2'd0, r); check_eq("sat_value_raw", r, 32'd1000000);
        wr(2'd2, 32'd2);
        rd(2'd2, r); check_eq("ovf_clear", r, 32'd0);

        // writes during busy: only first and latest values are displayed
        seen_q.delete();
        mon_last = cur_pack();
        mon_on = 1'b1;
        wr(2'd0, 32'd111111);
        repeat (4) tick();
        wr(2'd0, 32'd222222);
        tick();
        wr(2'd0, 32'd333333);
        repeat (16) tick();
        check_display("busy_first", 111111, 1, 0);
        repeat (23) tick();
        check_display("busy_second", 333333, 1, 0);
        rd(2'd2, r); check_eq("busy_done", r, 32'd0);
        repeat (30) tick();
        rd(2'd2, r); check_eq("busy_no_third", r, 32'd0);
        mon_on = 1'b0;
        check_eq("busy_nseen", seen_q.size(), 32'd2);
        if (seen_q.size() == 2) begin
            check_eq("busy_seq0", 32'(seen_q[0]), 32'(exp_pack(111111, 1, 0)));
            check_eq("busy_seq1", 32'(seen_q[1] >> 21), 32'(exp_pack(333333, 1, 0) >> 21));
        end

        // randomized transactions against the display model
        en_m = 1'b1; blz_m = 1'b0; ovf_m = 1'b0;
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 1048575);
                1: v = $urandom_range(0, 999);
                2: v = $urandom_range(999990, 1000010);
                default: v = $urandom_range(0, 99999);
            endcase
            en_m  = ($urandom_range(0, 3) != 0);
            blz_m = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) begin
                wr(2'd2, 32'd2);
                ovf_m = 1'b0;
            end
            wr(2'd1, {30'd0, en_m, blz_m});
            wr(2'd0, v);
            repeat (23) tick();
            if (v > 999999) ovf_m = 1'b1;
            check_display($sformatf("rnd%0d", n), v, en_m, blz_m);
            rd(2'd2, r); check_eq($sformatf("rnd%0d_status", n), r, {30'd0, ovf_m, 1'b0});
            rd(2'd0, r); check_eq($sformatf("rnd%0d_value", n), r, v);
        end

        // reset mid-conversion
        wr(2'd0, 32'd777777);
        repeat (11) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_display("rstmid_now", 0, 1, 0);
        rd(2'd2, r); check_eq("rstmid_busy", r, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (30) tick();
        check_display("rstmid_after", 0, 1, 0);
        rd(2'd0, r); check_eq("rstmid_value", r, 32'd0);
        rd(2'd1, r); check_eq("rstmid_ctrl", r, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_hex_driver.md
SCORE_HEX_DRIVER -- requirements
Module: score_hex_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of seven-segment digits driven.
REQ-002 SHALL have parameter VALUE_W, default 20, width of the binary value register.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port address, input, 2, Avalon-MM word address.
REQ-006 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-007 SHALL have port write_n, input, 1, Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-009 SHALL have port readdata, output, 32, combinational read data; zero-wait, no read strobe.
REQ-010 SHALL have ports hex0..hex5, output, 7 each, segment patterns {g,f,e,d,c,b,a}, active-low (0 = lit); hex0 is the least-significant digit.

Function
REQ-011 A write is chipselect=1 and write_n=0 at a rising clk edge.
REQ-012 Address map:
- 0: VALUE, binary, bits[VALUE_W-1:0].
- 1: CTRL, bit0 = blank_lz (blank leading zeros), bit1 = en (display enable).
- 2: STATUS, bit0 = busy (read-only), bit1 = ovf (sticky, write 1 to clear).
- 3: reserved; reads 0, writes ignored.
REQ-013 readdata SHALL return the addressed register, zero-extended; unused bits read 0.
REQ-014 A write to VALUE SHALL store the value and set a pending flag.
REQ-015 Converter FSM states: IDLE, LOAD, SHIFT, LATCH.
REQ-016 IDLE -> LOAD when pending=1; LOAD clears pending and copies the value into the shift register.
REQ-017 LOAD saturation: a value > 999999 SHALL be replaced by 999999 and SHALL set ovf.
REQ-018 SHIFT SHALL run exactly VALUE_W cycles of serial double-dabble: add 3 to each BCD nibble >= 5, then shift left 1.
REQ-019 LATCH SHALL copy the 6 BCD digits to the display register in one cycle, then go to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Latency: a VALUE write at edge N updates hex outputs at edge N+VALUE_W+3 (N+23 with defaults).
REQ-022 A VALUE write while busy SHALL overwrite the stored value and re-set pending; the conversion in progress completes unchanged, then exactly one further conversion uses the latest value.
REQ-023 If a VALUE write coincides with LOAD clearing pending, pending SHALL end up set.
REQ-024 If a ovf clear write coincides with a saturating LOAD, ovf SHALL end up set.
REQ-025 Segment decode SHALL be combinational from the display register and CTRL: digits 0-9 use standard patterns; unused codes give 7'h7F.
REQ-026 When en=0, all hex outputs SHALL be 7'h7F.
REQ-027 When blank_lz=1, each zero digit above the most-significant nonzero digit SHALL be 7'h7F; hex0 is never blanked.
REQ-028 CTRL changes SHALL affect outputs on the next cycle without starting a conversion.

Reset
REQ-029 reset_n=0 SHALL asynchronously clear VALUE, pending, ovf, the BCD display register and the FSM (to IDLE).
REQ-030 reset_n=0 SHALL set CTRL to en=1, blank_lz=0, so every digit shows "0" (7'h40) after reset.
REQ-031 A reset asserted mid-conversion SHALL abort it; no partial result reaches the outputs.

Structure
REQ-032 A shared package score_hex_pkg SHALL hold:
- the address constants;
- the CTRL/STATUS bit indices;
- the FSM state enum;
- the constants MAX_VALUE=999999 and SEG_BLANK=7'h7F.
REQ-033 The per-digit BCD-to-segment decoder SHALL be one sub-module, seg7_decode, instantiated NUM_DIGITS times.

Verification
REQ-034 Reset check: release reset, no writes -> hex0..hex5 = 7'h40, STATUS reads 0.
REQ-035 Conversion and latency: write VALUE=123456 at edge N -> busy=1 from N+1; at N+23 hex5..hex0 show 1,2,3,4,5,6 (7'h79,7'h24,7'h30,7'h19,7'h12,7'h02); busy=0.
REQ-036 Leading-zero blanking: CTRL=3, VALUE=42 -> hex1=7'h19, hex0=7'h24, hex2..hex5=7'h7F. Then VALUE=0 -> hex0=7'h40, all others blank.
REQ-037 Saturation: VALUE=1000000 -> display 999999, STATUS=2'b10 after completion. Write STATUS=2 -> reads 0.
REQ-038 Write during busy: VALUE=111111, then VALUE=222222 and VALUE=333333 during SHIFT -> display shows 111111, then 333333; 222222 never appears; exactly two conversions occur.
REQ-039 Reset mid-conversion: VALUE=777777, reset_n pulsed low at cycle 10 of SHIFT -> outputs 7'h40 immediately, busy=0, 7 never displayed.
